// File: rtl/contador_controlador.sv
// Bounce-sweep sequencer for the up/down counter: start/done handshake with pause and abort.
// All outputs registered (1-cycle latency from start); pause freezes the run and abort ends it on the next edge.
module contador_controlador #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   cont,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweeps_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
  localparam logic [SWEEP_W-1:0] SW_ONE = SWEEP_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cont_q, cont_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic               cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] sweep_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cont_q    <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sweeps_q  <= '0;
      cfg_err_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sweeps_q  <= sweeps_d;
      cfg_err_q <= cfg_err_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      n_q       <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sweeps_d  = sweeps_q;
    cfg_err_d = 1'b0;
    lo_d      = lo_q;
    hi_d      = hi_q;
    n_d       = n_q;
    sweep_inc = sweeps_q + SW_ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((lo_lim >= hi_lim) || (n_sweeps == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d     = lo_lim;
            hi_d     = hi_lim;
            n_d      = n_sweeps;
            cont_d   = lo_lim;
            dir_d    = 1'b0;
            sweeps_d = '0;
            busy_d   = 1'b1;
            state_d  = S_UP;
          end
        end
      end
      S_UP: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          dir_d   = 1'b0;
        end else if (!pause) begin
          // The turn at the top costs no extra cycle: hi is followed directly by hi-1.
          if (cont_q == hi_q) begin
            cont_d  = hi_q - ONE;
            dir_d   = 1'b1;
            state_d = S_DOWN;
          end else begin
            cont_d = cont_q + ONE;
          end
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          dir_d   = 1'b0;
        end else if (!pause) begin
          if (cont_q != lo_q) begin
            cont_d = cont_q - ONE;
          end else begin
            sweeps_d = sweep_inc;
            if (sweep_inc == n_q) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cont_d  = lo_q + ONE;
              dir_d   = 1'b0;
              state_d = S_UP;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dir_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cont        = cont_q;
  assign direction   = dir_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sweeps_done = sweeps_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_contador_controlador.sv
// Scoreboard bench for contador_controlador: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever busy, done or cfg_err is presented.
module tb_contador_controlador;

  typedef struct packed {
    logic [3:0] cont;
    logic       dir;
    logic       busy;
    logic       done;
    logic [3:0] sw;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, abort;
  logic [3:0] lo_lim, hi_lim, n_sweeps;
  logic [3:0] cont;
  logic       direction, busy, done, cfg_err;
  logic [3:0] sweeps_done;

  obs_t  exp_q[$];
  obs_t  mon_exp;
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_test = "reset";

  int t1c[7]  = '{2, 3, 4, 5, 4, 3, 2};
  int t1d[7]  = '{0, 0, 0, 0, 1, 1, 1};
  int t4c[10] = '{1, 2, 3, 3, 3, 3, 4, 3, 2, 1};
  int t4d[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int t5c[8]  = '{1, 2, 3, 4, 5, 6, 5, 4};
  int t5d[8]  = '{0, 0, 0, 0, 0, 0, 1, 1};

  contador_controlador #(.WIDTH(4), .SWEEP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .lo_lim     (lo_lim),
    .hi_lim     (hi_lim),
    .n_sweeps   (n_sweeps),
    .cont       (cont),
    .direction  (direction),
    .busy       (busy),
    .done       (done),
    .sweeps_done(sweeps_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int c, input int d, input int b, input int dn,
                              input int s, input int e);
    obs_t o;
    o.cont = c[3:0];
    o.dir  = d[0];
    o.busy = b[0];
    o.done = dn[0];
    o.sw   = s[3:0];
    o.err  = e[0];
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cont = cont;
    o.dir  = direction;
    o.busy = busy;
    o.done = done;
    o.sw   = sweeps_done;
    o.err  = cfg_err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got cont=%0d dir=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want cont=%0d dir=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b",
               cur_test, name, act.cont, act.dir, act.busy, act.done, act.sw, act.err,
               exp.cont, exp.dir, exp.busy, exp.done, exp.sw, exp.err);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && (busy || done || cfg_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s/unexpected_output: got cont=%0d busy=%0b done=%0b cfg_err=%0b, want no output",
                 cur_test, cont, busy, done, cfg_err);
      end else begin
        mon_exp = exp_q.pop_front();
        check("monitor", observe(), mon_exp);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s/drain: got %0d expected outputs still pending, want 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_run(input int lo, input int hi, input int n);
    lo_lim   = lo[3:0];
    hi_lim   = hi[3:0];
    n_sweeps = n[3:0];
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Full bounce trace: first sweep starts at lo, later sweeps restart at lo+1.
  task automatic push_run(input int lo, input int hi, input int n);
    for (int s = 0; s < n; s++) begin
      for (int v = (s == 0) ? lo : lo + 1; v <= hi; v++) exp_q.push_back(mk(v, 0, 1, 0, s, 0));
      for (int v = hi - 1; v >= lo; v--) exp_q.push_back(mk(v, 1, 1, 0, s, 0));
    end
    exp_q.push_back(mk(lo, 1, 0, 1, n, 0));
  endtask

  task automatic reject(input int lo, input int hi, input int n, input int c, input int s);
    exp_q.push_back(mk(c, 0, 0, 0, s, 1));
    start_run(lo, hi, n);
    wait_drain(4);
    @(negedge clk);
    #1;
    check("after_reject", observe(), mk(c, 0, 0, 0, s, 0));
  endtask

  task automatic check_idle(input int c, input int s);
    @(negedge clk);
    #1;
    check("idle", observe(), mk(c, 0, 0, 0, s, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    lo_lim = '0; hi_lim = '0; n_sweeps = '0;
    #12;
    check("reset_values", observe(), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    cur_test = "basic";
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(t1c[i], t1d[i], 1, 0, 0, 0));
    exp_q.push_back(mk(2, 1, 0, 1, 1, 0));
    start_run(2, 5, 1);
    wait_drain(20);
    check_idle(2, 1);

    cur_test = "reject";
    reject(5, 5, 1, 2, 1);
    reject(3, 7, 0, 2, 1);
    reject(9, 3, 2, 2, 1);

    cur_test = "full_range";
    push_run(0, 15, 2);
    start_run(0, 15, 2);
    wait_drain(80);
    check_idle(0, 2);

    cur_test = "pause";
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(t4c[i], t4d[i], 1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 1, 1, 0));
    start_run(1, 4, 1);
    cycles(2);
    pause = 1'b1;
    cycles(3);
    pause = 1'b0;
    wait_drain(20);
    check_idle(1, 1);

    cur_test = "abort";
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(t5c[i], t5d[i], 1, 0, 0, 0));
    start_run(1, 6, 2);
    cycles(1);
    lo_lim = 4'd0; hi_lim = 4'd9; n_sweeps = 4'd3; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(5);
    abort = 1'b1;
    pause = 1'b1;
    cycles(1);
    abort = 1'b0;
    pause = 1'b0;
    #1;
    check("after_abort", observe(), mk(4, 0, 0, 0, 0, 0));
    cycles(3);
    wait_drain(2);
    check_idle(4, 0);

    cur_test = "async_reset";
    for (int v = 3; v <= 5; v++) exp_q.push_back(mk(v, 0, 1, 0, 0, 0));
    start_run(3, 9, 1);
    cycles(2);
    #2;
    reset = 1'b0;
    #1;
    check("in_reset", observe(), mk(0, 0, 0, 0, 0, 0));
    wait_drain(1);
    @(negedge clk);
    reset = 1'b1;
    push_run(2, 3, 1);
    start_run(2, 3, 1);
    wait_drain(10);
    check_idle(2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
